mult_arbiter: RTL



---
 rtl/mult_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one booth multiplier among NREQ requesters
// One operation in flight at a time; a watchdog turns a hung multiplier into an error response.
module mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 127
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [IDW-1:0]   resp_id,
  output logic [63:0]      resp_result,
  output logic             resp_err,
  output logic             mul_start,
  output logic [31:0]      mul_m,
  output logic [31:0]      mul_q,
  input  logic             mul_done,
  input  logic [63:0]      mul_result
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [31:0]      mul_m_q, mul_m_d;
  logic [31:0]      mul_q_q, mul_q_d;
  logic [63:0]      result_q, result_d;
  logic             err_q, err_d;
  logic [WDW-1:0]   wd_cnt_q, wd_cnt_d;

  logic             found;
  logic [IDW-1:0]   winner;
  int unsigned      idx;
  logic             wd_expired;

  // Search upward from rr_ptr, wrapping, for the first valid requester.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  assign wd_expired = (wd_cnt_q == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      mul_m_q  <= '0;
      mul_q_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      mul_m_q  <= mul_m_d;
      mul_q_q  <= mul_q_d;
      result_q <= result_d;
      err_q    <= err_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mul_done || wd_expired) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state; done has priority over the watchdog in the same cycle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    mul_m_d  = mul_m_q;
    mul_q_d  = mul_q_q;
    result_d = result_q;
    err_d    = err_q;
    wd_cnt_d = wd_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          id_d    = winner;
          mul_m_d = req_a[32*winner +: 32];
          mul_q_d = req_b[32*winner +: 32];
        end
      end
      ISSUE: wd_cnt_d = '0;
      WAIT: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        if (mul_done) begin
          result_d = mul_result;
          err_d    = 1'b0;
        end else if (wd_expired) begin
          result_d = '0;
          err_d    = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    mul_start  = 1'b0;
    resp_valid = 1'b0;
    if (state_q == IDLE && found) req_ready = NREQ'(1) << winner;
    if (state_q == ISSUE) mul_start = 1'b1;
    if (state_q == RESP) resp_valid = 1'b1;
  end

  assign mul_m       = mul_m_q;
  assign mul_q       = mul_q_q;
  assign resp_id     = id_q;
  assign resp_result = result_q;
  assign resp_err    = err_q;

endmodule
